// File: rtl/mult_pkg.sv
// Shared encodings and width helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Start/done/ack handshake plus operand and product buses between host and multiplier.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               ack_i;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] product_o;

  modport master (
    output start_i, a_i, b_i, ack_i,
    input  busy_o, done_o, product_o
  );

  modport slave (
    input  start_i, a_i, b_i, ack_i,
    output busy_o, done_o, product_o
  );
endinterface

// File: rtl/mult_reg_en.sv
// Parameterised register with load enable and synchronous active-low clear.
module mult_reg_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (!reset_n)  q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/mult_seq_fsm.sv
// IDLE/RUN/DONE sequencer: owns state and iteration count, emits load/iterate enables.
module mult_seq_fsm
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic ack_i,
  output logic load_o,
  output logic iter_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fixed WIDTH iterations; no early exit on a zero multiplier.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    iter_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        iter_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded straight from the state register: no input-to-output path.
  assign busy_o = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Unsigned shift-and-add multiplier: sequencer plus multiplicand/multiplier/accumulator datapath.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int PW = prod_w(WIDTH);

  logic          load, iter, en;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;

  mult_seq_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (bus.start_i),
    .ack_i   (bus.ack_i),
    .load_o  (load),
    .iter_o  (iter),
    .busy_o  (bus.busy_o),
    .done_o  (bus.done_o)
  );

  assign en = load | iter;

  always_comb begin
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    if (load) begin
      mcand_d  = {{(PW-WIDTH){1'b0}}, bus.a_i};
      mplier_d = bus.b_i;
      acc_d    = '0;
    end
  end

  mult_reg_en #(.W(PW))    u_mcand  (.clk(clk), .reset_n(reset_n), .en_i(en), .d_i(mcand_d),  .q_o(mcand_q));
  mult_reg_en #(.W(WIDTH)) u_mplier (.clk(clk), .reset_n(reset_n), .en_i(en), .d_i(mplier_d), .q_o(mplier_q));
  mult_reg_en #(.W(PW))    u_acc    (.clk(clk), .reset_n(reset_n), .en_i(en), .d_i(acc_d),    .q_o(acc_q));

  assign bus.product_o = acc_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl (WIDTH=8): stimulus pushes expected products, monitor checks on done rise.
module tb_mult_seq_ctrl;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] prod;
    int            acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic done_prev = 1'b0;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rising done_o is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.done_o && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(bus.done_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("product", 32'(bus.product_o), 32'(e.prod));
        chk("latency", 32'(cyc - e.acc_cyc), 32'(W));
      end
    end
    if (bus.done_o) chk("done_implies_busy", 32'(bus.busy_o), 32'd1);
    done_prev <= bus.done_o;
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] exp_p);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) chk("idle_timeout", 32'(bus.busy_o), 32'd0);
    bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    e.prod = exp_p;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done_o) chk("done_timeout", 32'(bus.done_o), 32'd1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    bus.ack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ack_i = 1'b0;
    @(negedge clk);
    chk("ack_done_low", 32'(bus.done_o), 32'd0);
    chk("ack_busy_low", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [PW-1:0] hold_p;
    bus.start_i = 1'b0; bus.ack_i = 1'b0; bus.a_i = '0; bus.b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_product", 32'(bus.product_o), 32'd0);
    reset_n = 1'b1;

    // 5 * 3
    start_op(8'd5, 8'd3, 16'd15);
    @(negedge clk);
    chk("busy_after_accept", 32'(bus.busy_o), 32'd1);
    chk("not_done_early", 32'(bus.done_o), 32'd0);
    wait_done();
    do_ack();
    chk("product_held_idle", 32'(bus.product_o), 32'd15);

    // Corner operands
    start_op(8'd255, 8'd255, 16'hFE01); wait_done(); do_ack();
    start_op(8'd0,   8'd200, 16'd0);    wait_done(); do_ack();
    start_op(8'd200, 8'd0,   16'd0);    wait_done(); do_ack();

    // Start held high; operands change mid-run
    @(negedge clk);
    bus.a_i = 8'd7; bus.b_i = 8'd9; bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    e.prod = 16'd63; e.acc_cyc = cyc; exp_q.push_back(e);
    @(negedge clk);
    bus.a_i = 8'd1; bus.b_i = 8'd1;
    wait_done();
    repeat (3) @(negedge clk);
    chk("no_retrigger_done", 32'(bus.done_o), 32'd1);
    chk("no_retrigger_prod", 32'(bus.product_o), 32'd63);
    bus.ack_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ack_i = 1'b0;
    @(negedge clk);
    chk("held_start_idle_gap", 32'(bus.busy_o), 32'd0);
    @(posedge clk);
    #1;
    e.prod = 16'd1; e.acc_cyc = cyc; exp_q.push_back(e);
    bus.start_i = 1'b0;
    wait_done();
    do_ack();

    // Long DONE hold, then ack+start on the same edge
    start_op(8'd12, 8'd11, 16'd132);
    wait_done();
    hold_p = bus.product_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.done_o || bus.product_o !== hold_p) begin
        chk("done_hold_done", 32'(bus.done_o), 32'd1);
        chk("done_hold_prod", 32'(bus.product_o), 32'(hold_p));
      end
    end
    chk("done_hold_final", 32'(bus.product_o), 32'd132);
    @(negedge clk);
    bus.ack_i = 1'b1; bus.start_i = 1'b1; bus.a_i = 8'd3; bus.b_i = 8'd3;
    @(posedge clk);
    #1;
    bus.ack_i = 1'b0; bus.start_i = 1'b0;
    @(negedge clk);
    chk("ack_start_busy", 32'(bus.busy_o), 32'd0);
    chk("ack_start_prod", 32'(bus.product_o), 32'd132);

    // Reset during the fourth iteration
    start_op(8'd100, 8'd100, 16'd10000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    chk("midrst_prod", 32'(bus.product_o), 32'd0);
    start_op(8'd100, 8'd100, 16'd10000); wait_done(); do_ack();

    // Random operand pairs against a*b
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      start_op(ra, rb, PW'(ra) * PW'(rb));
      wait_done();
      do_ack();
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencing controller and datapath for the multiplier peripheral. It is an unsigned shift-and-add engine that accepts an operand pair from the SPI-facing register block via a start/done/ack handshake. It runs a fixed WIDTH-cycle iteration that drives the operand and accumulator register enables. It holds the product until the host acknowledges it.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on posedge clk.
reset_n  input  1  synchronous reset, active-low; sampled on posedge clk.
start_i  input  1  request to begin a multiply; honoured only in IDLE.
a_i  input  WIDTH  multiplicand; sampled on the accepting edge only.
b_i  input  WIDTH  multiplier; sampled on the accepting edge only.
ack_i  input  1  host has read product_o; honoured only in DONE.
busy_o  output  1  high in RUN and DONE.
done_o  output  1  high in DONE; product_o valid.
product_o  output  2*WIDTH  accumulated product; held until the next accepted start.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset: reset_n=0 at a posedge forces state=IDLE. Accumulator, multiplicand register, multiplier register and count are all cleared. Outputs are busy_o=0, done_o=0, product_o=0. Reset has priority over every other input, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE, start_i=1 at edge k (the accepting edge):
  - multiplicand reg <= zero-extended a_i (2*WIDTH bits)
  - multiplier reg <= b_i
  - accumulator <= 0; count <= 0; state <= RUN
- IDLE, start_i=0: all registers hold (per-register enable low).
- RUN, each edge:
  - if multiplier[0]=1, accumulator <= accumulator + multiplicand, truncated to 2*WIDTH bits (cannot overflow for unsigned operands)
  - multiplicand <<= 1; multiplier >>= 1; count <= count+1
  - when count==WIDTH-1 on this edge, state <= DONE
- RUN length:
  - exactly WIDTH edges; no early exit when the multiplier becomes zero
  - done_o rises after edge k+WIDTH, i.e. accept-to-done latency is WIDTH cycles
- RUN, start_i: ignored; operands are not re-sampled.
- RUN, ack_i: ignored.
- DONE: done_o=1; accumulator holds.
  - ack_i=1 -> state <= IDLE; done_o falls the next cycle.
  - start_i in DONE is ignored, even on the same edge as ack_i. A new start is accepted no earlier than the first IDLE cycle.
- product_o: continuously driven from the accumulator. It therefore changes during RUN, but is only guaranteed valid while done_o=1. It stays stable through IDLE until the next accepting edge clears it.
- count width: clog2(WIDTH)+1 bits; it wraps only through an explicit clear on accept.
- busy_o and done_o are registered or decoded directly from the state register, with no combinational path from inputs.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - PROD_W = 2*WIDTH helper
- One natural sub-module: mult_seq_fsm. It holds the state register and count, and produces the load/iterate/hold enables and busy/done.
- The top level holds the three enable-gated registers (multiplicand, multiplier, accumulator), built from the team's parameterised register-with-enable primitive, plus the adder.

Test Plan:
- WIDTH=8, reset, then start with a=5, b=3 -> busy_o=1 next cycle; done_o=1 exactly 8 cycles after accept; product_o=15; ack -> done_o=0, busy_o=0 next cycle.
- a=255, b=255 -> product_o=65025 (0xFE01). Then a=0, b=200 -> 0. Then a=200, b=0 -> 0. Latency is 8 cycles in every case.
- Start held high continuously with a=7, b=9. Operands change to a=1, b=1 during RUN -> product_o=63; no re-trigger in RUN or DONE. After ack, the next accepted start uses the current a/b one cycle later.
- Hold ack_i low for 20 cycles in DONE -> done_o and product_o stay stable. Assert ack_i and start_i on the same edge -> start ignored; IDLE for at least one cycle.
- Assert reset_n=0 for one edge at iteration 4 of a=100, b=100 -> the next cycle shows busy_o=0, done_o=0, product_o=0. A fresh start then yields 10000.
- Randomised 200 operand pairs against a reference a*b -> every product matches; every latency is exactly WIDTH; done_o is never asserted outside DONE.
